period_meter: RTL and testbench

- Measures the slow clocks produced by the design's frequency dividers and feeds them back into the fast clock domain. This is the receiving end of a divided clock.
- Synchronizes an asynchronous slow square wave `sig_in` to `clk`, emits a one-cycle `edge_tick` per rising edge, and measures period and high time in `clk` cycles.
- Used to check divider outputs on hardware and to give downstream logic clock enables instead of derived clocks.

---
 rtl/period_meter.sv | 122 ++++++++++++
 tb/tb_period_meter.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/period_meter.sv
// period_meter
// Receives a slow, asynchronous square wave (typically a divided clock),
// brings it into the clk domain, emits a one-cycle clock enable on each rising
// edge and measures the period and high time of the wave in clk cycles.
// Downstream logic should use edge_tick as an enable instead of clocking
// anything from sig_in directly.
module period_meter #(
    parameter int CNT_W       = 24,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sig_in,
    input  logic             enable,
    output logic             edge_tick,
    output logic [CNT_W-1:0] period,
    output logic [CNT_W-1:0] high_time,
    output logic             period_valid,
    output logic             overflow
);

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] ARM     = 2'd1;
    localparam logic [1:0] MEASURE = 2'd2;

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   s_lvl;
    logic                   prev;
    logic [1:0]             state;
    logic [CNT_W-1:0]       cnt;
    logic [CNT_W-1:0]       hcnt;
    logic [CNT_W-1:0]       prev_ext;

    assign s_lvl    = sync_q[SYNC_STAGES-1];
    assign prev_ext = {{(CNT_W-1){1'b0}}, prev};

    // Shift the asynchronous input through the metastability chain; bit 0 is
    // the first flop to see sig_in, the top bit is the settled level s_lvl.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], sig_in};
        end
    end

    // Keep one cycle of level history and register the rising-edge pulse;
    // this runs independently of enable so the tick is always available.
    always_ff @(posedge clk) begin
        if (rst) begin
            prev      <= 1'b0;
            edge_tick <= 1'b0;
        end else begin
            prev      <= s_lvl;
            edge_tick <= s_lvl & ~prev;
        end
    end

    // Measurement FSM: the first tick after arming only starts counting,
    // every later tick closes a period and publishes the counts.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            cnt          <= '0;
            hcnt         <= '0;
            period       <= '0;
            high_time    <= '0;
            period_valid <= 1'b0;
            overflow     <= 1'b0;
        end else begin
            period_valid <= 1'b0;
            if (!enable) begin
                state    <= IDLE;
                cnt      <= '0;
                hcnt     <= '0;
                overflow <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        cnt   <= '0;
                        hcnt  <= '0;
                        state <= ARM;
                    end
                    ARM: begin
                        if (edge_tick) begin
                            cnt   <= CNT_ONE;
                            hcnt  <= CNT_ONE;
                            state <= MEASURE;
                        end
                    end
                    MEASURE: begin
                        if (edge_tick) begin
                            period       <= cnt;
                            high_time    <= hcnt;
                            period_valid <= 1'b1;
                            overflow     <= 1'b0;
                            cnt          <= CNT_ONE;
                            hcnt         <= CNT_ONE;
                        end else if (cnt != CNT_MAX) begin
                            cnt  <= cnt + CNT_ONE;
                            hcnt <= hcnt + prev_ext;
                        end else begin
                            overflow <= 1'b1;
                            cnt      <= '0;
                            hcnt     <= '0;
                            state    <= ARM;
                        end
                    end
                    default: begin
                        cnt   <= '0;
                        hcnt  <= '0;
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_period_meter.sv
// tb_period_meter
// Directed bench for period_meter. Instance a uses the default 24-bit counters,
// instance b uses 4-bit counters so the overflow path is reachable quickly.
// Inputs change 1 ns after each rising clk edge and outputs are sampled there.
module tb_period_meter;

    logic        clk = 1'b0;
    logic        rst;

    logic        sig_a, en_a, tick_a, pv_a, ovf_a;
    logic [23:0] period_a, high_a;

    logic        sig_b, en_b, tick_b, pv_b, ovf_b;
    logic [3:0]  period_b, high_b;

    int vectors     = 0;
    int miscompares = 0;

    bit wave_a_on = 1'b0;
    int per_a = 16, hi_a = 5, ph_a = 0;
    bit wave_b_on = 1'b0;
    int per_b = 10, hi_b = 3, ph_b = 0;

    period_meter u_dut_a (
        .clk          (clk),
        .rst          (rst),
        .sig_in       (sig_a),
        .enable       (en_a),
        .edge_tick    (tick_a),
        .period       (period_a),
        .high_time    (high_a),
        .period_valid (pv_a),
        .overflow     (ovf_a)
    );

    period_meter #(.CNT_W(4), .SYNC_STAGES(2)) u_dut_b (
        .clk          (clk),
        .rst          (rst),
        .sig_in       (sig_b),
        .enable       (en_b),
        .edge_tick    (tick_b),
        .period       (period_b),
        .high_time    (high_b),
        .period_valid (pv_b),
        .overflow     (ovf_b)
    );

    // Free-running 100 MHz system clock.
    always #5 clk = ~clk;

    // Hard stop in case something never terminates.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: observed timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    // Advance one clk cycle, then drive the square-wave generators for the
    // new cycle; each generator level lasts exactly one clk period.
    task automatic apply_stimulus();
        @(posedge clk);
        #1;
        if (wave_a_on) begin
            sig_a = (ph_a < hi_a);
            ph_a  = (ph_a + 1 >= per_a) ? 0 : ph_a + 1;
        end
        if (wave_b_on) begin
            sig_b = (ph_b < hi_b);
            ph_b  = (ph_b + 1 >= per_b) ? 0 : ph_b + 1;
        end
    endtask

    task automatic check_output(input string tag, input logic [31:0] obs,
                                input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("[TB] FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    // Step until instance a ticks, bounded by max cycles.
    task automatic wait_tick_a(input int max, input string tag);
        int n;
        apply_stimulus();
        n = 1;
        while (tick_a !== 1'b1 && n < max) begin
            apply_stimulus();
            n++;
        end
        check_output(tag, 32'(tick_a), 32'd1);
    endtask

    task automatic wait_tick_b(input int max, input string tag);
        int n;
        apply_stimulus();
        n = 1;
        while (tick_b !== 1'b1 && n < max) begin
            apply_stimulus();
            n++;
        end
        check_output(tag, 32'(tick_b), 32'd1);
    endtask

    // Step until instance a publishes a result, bounded by max cycles.
    task automatic wait_pv_a(input int max, input string tag);
        int n;
        apply_stimulus();
        n = 1;
        while (pv_a !== 1'b1 && n < max) begin
            apply_stimulus();
            n++;
        end
        check_output(tag, 32'(pv_a), 32'd1);
    endtask

    // Step n cycles on instance a expecting no result and a held period.
    task automatic run_no_pv_a(input int n, input logic [23:0] hold, input string tag);
        logic bad_pv, bad_per;
        bad_pv  = 1'b0;
        bad_per = 1'b0;
        for (int i = 0; i < n; i++) begin
            apply_stimulus();
            if (pv_a !== 1'b0)   bad_pv  = 1'b1;
            if (period_a !== hold) bad_per = 1'b1;
        end
        check_output({tag, "_no_pv"}, 32'(bad_pv), 32'd0);
        check_output({tag, "_period_hold"}, 32'(bad_per), 32'd0);
    endtask

    // Directed sequence.
    initial begin
        logic flag;

        rst   = 1'b1;
        sig_a = 1'b0;
        en_a  = 1'b0;
        sig_b = 1'b0;
        en_b  = 1'b0;
        apply_stimulus();
        apply_stimulus();
        check_output("rst_tick",   32'(tick_a),   32'd0);
        check_output("rst_period", 32'(period_a), 32'd0);
        check_output("rst_high",   32'(high_a),   32'd0);
        check_output("rst_pv",     32'(pv_a),     32'd0);
        check_output("rst_ovf",    32'(ovf_a),    32'd0);
        check_output("rst_ovf_b",  32'(ovf_b),    32'd0);
        rst = 1'b0;

        // Single rise: sampled at edge k, tick only in the cycle after k+2.
        en_a = 1'b1;
        for (int i = 0; i < 4; i++) apply_stimulus();
        sig_a = 1'b1;
        apply_stimulus();
        check_output("lat_k",   32'(tick_a), 32'd0);
        apply_stimulus();
        check_output("lat_k1",  32'(tick_a), 32'd0);
        apply_stimulus();
        check_output("lat_k2",  32'(tick_a), 32'd1);
        apply_stimulus();
        check_output("lat_k3",  32'(tick_a), 32'd0);
        run_no_pv_a(20, 24'd0, "arm_only");

        // Re-arm, then a 16-cycle wave with 5 cycles high.
        sig_a = 1'b0;
        en_a  = 1'b0;
        for (int i = 0; i < 4; i++) apply_stimulus();
        en_a = 1'b1;
        apply_stimulus();
        apply_stimulus();
        per_a = 16; hi_a = 5; ph_a = 0; wave_a_on = 1'b1;
        wait_tick_a(40, "p16_first_tick");
        check_output("p16_first_tick_pv", 32'(pv_a), 32'd0);
        run_no_pv_a(16, 24'd0, "p16_first");
        check_output("p16_second_tick", 32'(tick_a), 32'd1);
        apply_stimulus();
        check_output("p16_pv1",     32'(pv_a),     32'd1);
        check_output("p16_period1", 32'(period_a), 32'd16);
        check_output("p16_high1",   32'(high_a),   32'd5);
        check_output("p16_ovf1",    32'(ovf_a),    32'd0);
        run_no_pv_a(15, 24'd16, "p16_gap");
        apply_stimulus();
        check_output("p16_pv2",     32'(pv_a),     32'd1);
        check_output("p16_period2", 32'(period_a), 32'd16);

        // Enable dropped for one cycle right after a result.
        en_a = 1'b0;
        apply_stimulus();
        check_output("endrop_pv", 32'(pv_a), 32'd0);
        en_a = 1'b1;
        run_no_pv_a(30, 24'd16, "endrop");
        apply_stimulus();
        check_output("endrop_pv_back", 32'(pv_a),     32'd1);
        check_output("endrop_period",  32'(period_a), 32'd16);
        check_output("endrop_high",    32'(high_a),   32'd5);
        check_output("endrop_ovf",     32'(ovf_a),    32'd0);

        // Reset mid-measurement, in the low phase of the wave.
        run_no_pv_a(8, 24'd16, "pre_rst");
        rst = 1'b1;
        apply_stimulus();
        check_output("midrst_tick",   32'(tick_a),   32'd0);
        check_output("midrst_period", 32'(period_a), 32'd0);
        check_output("midrst_high",   32'(high_a),   32'd0);
        check_output("midrst_pv",     32'(pv_a),     32'd0);
        check_output("midrst_ovf",    32'(ovf_a),    32'd0);
        rst = 1'b0;
        wait_tick_a(20, "postrst_arm_tick");
        run_no_pv_a(16, 24'd0, "postrst");
        apply_stimulus();
        check_output("postrst_pv",     32'(pv_a),     32'd1);
        check_output("postrst_period", 32'(period_a), 32'd16);
        check_output("postrst_high",   32'(high_a),   32'd5);

        // Period 4, high 2.
        per_a = 4; hi_a = 2; ph_a = 0;
        wait_pv_a(40, "p4_settle1");
        wait_pv_a(40, "p4_settle2");
        wait_pv_a(40, "p4_pv");
        check_output("p4_period", 32'(period_a), 32'd4);
        check_output("p4_high",   32'(high_a),   32'd2);
        run_no_pv_a(3, 24'd4, "p4_gap");
        apply_stimulus();
        check_output("p4_pv_next", 32'(pv_a), 32'd1);

        // Period 2, high 1 (fastest measurable input).
        per_a = 2; hi_a = 1; ph_a = 0;
        wait_pv_a(40, "p2_settle1");
        wait_pv_a(40, "p2_settle2");
        wait_pv_a(40, "p2_pv");
        check_output("p2_period", 32'(period_a), 32'd2);
        check_output("p2_high",   32'(high_a),   32'd1);
        run_no_pv_a(1, 24'd2, "p2_gap");
        apply_stimulus();
        check_output("p2_pv_next", 32'(pv_a),     32'd1);
        check_output("p2_period2", 32'(period_a), 32'd2);

        // 4-bit instance: one rise then low long enough to overflow.
        en_b = 1'b1;
        apply_stimulus();
        apply_stimulus();
        sig_b = 1'b1;
        wait_tick_b(10, "ovf_arm_tick");
        sig_b = 1'b0;
        check_output("ovf_arm_pv", 32'(pv_b), 32'd0);
        flag = 1'b0;
        for (int i = 0; i < 15; i++) begin
            apply_stimulus();
            if (ovf_b !== 1'b0 || pv_b !== 1'b0) flag = 1'b1;
        end
        check_output("ovf_early", 32'(flag), 32'd0);
        apply_stimulus();
        check_output("ovf_set",    32'(ovf_b),    32'd1);
        check_output("ovf_period", 32'(period_b), 32'd0);
        check_output("ovf_pv",     32'(pv_b),     32'd0);
        for (int i = 0; i < 3; i++) apply_stimulus();
        check_output("ovf_sticky", 32'(ovf_b), 32'd1);

        // Two edges 10 apart after overflow: first arms, second measures.
        per_b = 10; hi_b = 3; ph_b = 0; wave_b_on = 1'b1;
        wait_tick_b(20, "ovf_rearm_tick");
        check_output("ovf_rearm_ovf", 32'(ovf_b), 32'd1);
        check_output("ovf_rearm_pv",  32'(pv_b),  32'd0);
        flag = 1'b0;
        for (int i = 0; i < 10; i++) begin
            apply_stimulus();
            if (pv_b !== 1'b0) flag = 1'b1;
        end
        check_output("ovf_rearm_no_pv", 32'(flag), 32'd0);
        apply_stimulus();
        check_output("p10_pv",     32'(pv_b),     32'd1);
        check_output("p10_period", 32'(period_b), 32'd10);
        check_output("p10_high",   32'(high_b),   32'd3);
        check_output("p10_ovf",    32'(ovf_b),    32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
